// File: rtl/cnn_seq_ctrl.sv
// cnn_seq_ctrl
//   Sequencing controller for the CNN datapath. Accepts an image burst
//   (in_valid_1) and a kernel burst (in_valid_2), producing write
//   addresses for the two buffers. It then walks every valid convolution
//   window, one tap per cycle, driving buffer read addresses and MAC
//   control. It flags each finished window with acc_store/out_idx and
//   ends the frame with a one-cycle done pulse.
//
// Ports
//   clk, rst_n           clock, async active-low reset
//   in_valid_1/2         image / kernel beat valid
//   img_we, img_addr     image buffer write enable / address (write, then read)
//   ker_we, ker_addr     kernel buffer write enable / address (write, then read)
//   mac_en, mac_clr      MAC accumulate enable / clear-and-load on first tap
//   acc_store, out_idx   window result valid at MAC output, window index
//   busy, done, err      frame in progress, frame-complete pulse, sticky error
module cnn_seq_ctrl #(
  parameter int IMG_W = 8,
  parameter int K_W   = 3,
  parameter int IA_W  = 6,
  parameter int KA_W  = 4,
  parameter int OA_W  = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid_1,
  input  logic            in_valid_2,
  output logic            img_we,
  output logic [IA_W-1:0] img_addr,
  output logic            ker_we,
  output logic [KA_W-1:0] ker_addr,
  output logic            mac_en,
  output logic            mac_clr,
  output logic            acc_store,
  output logic [OA_W-1:0] out_idx,
  output logic            busy,
  output logic            done,
  output logic            err
);

  localparam int OUT_W = IMG_W - K_W + 1;
  localparam int IMG_N = IMG_W * IMG_W;
  localparam int KER_N = K_W * K_W;
  localparam int RW    = (OUT_W > 1) ? $clog2(OUT_W) : 1;
  localparam int KB    = (K_W > 1) ? $clog2(K_W) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD_IMG, S_LOAD_KER, S_CONV, S_DRAIN, S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [IA_W-1:0] pix_q, pix_d;
  logic [KA_W-1:0] kcnt_q, kcnt_d;
  logic [RW-1:0]   r_q, r_d, c_q, c_d;
  logic [KB-1:0]   kr_q, kr_d, kc_q, kc_d;
  logic            drain_q, drain_d;
  logic            err_q, err_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  // Two-stage delay matching buffer read + MAC register latency.
  logic [1:0]            st_pipe_q, st_pipe_d;
  logic [1:0][OA_W-1:0]  idx_pipe_q, idx_pipe_d;

  logic            kc_last, kr_last, c_last, r_last, last_tap;
  logic            any_v;
  logic [IA_W-1:0] tap_img_addr;
  logic [KA_W-1:0] tap_ker_addr;
  logic [OA_W-1:0] win_idx;

  assign any_v    = in_valid_1 | in_valid_2;
  assign kc_last  = (kc_q == KB'(K_W - 1));
  assign kr_last  = (kr_q == KB'(K_W - 1));
  assign c_last   = (c_q == RW'(OUT_W - 1));
  assign r_last   = (r_q == RW'(OUT_W - 1));
  assign last_tap = (state_q == S_CONV) && kc_last && kr_last;

  assign tap_img_addr = IA_W'((32'(r_q) + 32'(kr_q)) * IMG_W + 32'(c_q) + 32'(kc_q));
  assign tap_ker_addr = KA_W'(32'(kr_q) * K_W + 32'(kc_q));
  assign win_idx      = OA_W'(32'(r_q) * OUT_W + 32'(c_q));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      pix_q      <= '0;
      kcnt_q     <= '0;
      r_q        <= '0;
      c_q        <= '0;
      kr_q       <= '0;
      kc_q       <= '0;
      drain_q    <= 1'b0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      st_pipe_q  <= '0;
      idx_pipe_q <= '0;
    end else begin
      state_q    <= state_d;
      pix_q      <= pix_d;
      kcnt_q     <= kcnt_d;
      r_q        <= r_d;
      c_q        <= c_d;
      kr_q       <= kr_d;
      kc_q       <= kc_d;
      drain_q    <= drain_d;
      err_q      <= err_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      st_pipe_q  <= st_pipe_d;
      idx_pipe_q <= idx_pipe_d;
    end
  end

  // Next-state and counter update
  always_comb begin
    state_d = state_q;
    pix_d   = pix_q;
    kcnt_d  = kcnt_q;
    r_d     = r_q;
    c_d     = c_q;
    kr_d    = kr_q;
    kc_d    = kc_q;
    drain_d = drain_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid_2) err_d = 1'b1;
        else if (in_valid_1) begin
          // Start beat itself is written to address 0.
          state_d = S_LOAD_IMG;
          pix_d   = IA_W'(1);
          err_d   = 1'b0;
        end
      end
      S_LOAD_IMG: begin
        if (in_valid_2) err_d = 1'b1;
        else if (in_valid_1) begin
          if (pix_q == IA_W'(IMG_N - 1)) begin
            pix_d   = '0;
            state_d = S_LOAD_KER;
          end else pix_d = pix_q + 1'b1;
        end
      end
      S_LOAD_KER: begin
        if (in_valid_1) err_d = 1'b1;
        else if (in_valid_2) begin
          if (kcnt_q == KA_W'(KER_N - 1)) begin
            kcnt_d  = '0;
            state_d = S_CONV;
          end else kcnt_d = kcnt_q + 1'b1;
        end
      end
      S_CONV: begin
        if (any_v) err_d = 1'b1;
        // kc fastest, then kr, then c, then r; all wrap to 0 on the final tap.
        kc_d = kc_last ? '0 : kc_q + 1'b1;
        if (kc_last) begin
          kr_d = kr_last ? '0 : kr_q + 1'b1;
          if (kr_last) begin
            c_d = c_last ? '0 : c_q + 1'b1;
            if (c_last) begin
              r_d = r_last ? '0 : r_q + 1'b1;
              if (r_last) state_d = S_DRAIN;
            end
          end
        end
      end
      S_DRAIN: begin
        if (any_v) err_d = 1'b1;
        drain_d = ~drain_q;
        if (drain_q) state_d = S_DONE;
      end
      S_DONE: begin
        if (any_v) err_d = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Registered status and result-tag pipeline
  always_comb begin
    busy_d        = (state_d != S_IDLE);
    done_d        = (state_d == S_DONE);
    st_pipe_d     = {st_pipe_q[0], last_tap};
    idx_pipe_d    = idx_pipe_q;
    idx_pipe_d[1] = idx_pipe_q[0];
    if (last_tap) idx_pipe_d[0] = win_idx;
  end

  // Outputs
  always_comb begin
    img_we   = 1'b0;
    ker_we   = 1'b0;
    img_addr = '0;
    ker_addr = '0;
    mac_en   = 1'b0;
    mac_clr  = 1'b0;
    case (state_q)
      S_IDLE:     img_we = rst_n & in_valid_1 & ~in_valid_2;
      S_LOAD_IMG: begin
        img_we   = in_valid_1 & ~in_valid_2;
        img_addr = pix_q;
      end
      S_LOAD_KER: begin
        ker_we   = in_valid_2 & ~in_valid_1;
        ker_addr = kcnt_q;
      end
      S_CONV: begin
        mac_en   = 1'b1;
        mac_clr  = (kr_q == '0) && (kc_q == '0);
        img_addr = tap_img_addr;
        ker_addr = tap_ker_addr;
      end
      default: ;
    endcase
  end

  assign acc_store = st_pipe_q[1];
  assign out_idx   = idx_pipe_q[1];
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule
